// File: rtl/pipeline_pkg.sv
// +--------------------------------------------------------------------+
// | pipeline_pkg: shared FSM encoding and MIPS opcode/funct constants  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_IRQ_HOLD = 2'd2
  } hz_state_e;

  localparam logic [5:0] OP_BLTZ = 6'd1;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_BLEZ = 6'd6;
  localparam logic [5:0] OP_BGTZ = 6'd7;

  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_JALR = 6'd9;

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// +--------------------------------------------------------------------+
// | hazard_match: does a stage's destination feed the ID sources?      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_match (
  input  logic       reg_wr,
  input  logic [4:0] wr_reg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       match
);

  logic dest_live;

  // $0 is hard-wired, so writes to it never create a dependency.
  assign dest_live = reg_wr && (wr_reg != 5'd0);
  assign match     = dest_live && ((wr_reg == id_rs) || (id_uses_rt && (wr_reg == id_rt)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush/forward and IRQ entry sequencing |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_BR_STALL = 2,
  parameter int IRQ_HOLDOFF   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Branch,
  input  logic       ID_Jump,
  input  logic       ID_JR,
  input  logic       ID_Taken,
  input  logic       ID_Kernel,
  input  logic       EX_RegWr,
  input  logic       EX_MemRd,
  input  logic [4:0] EX_WrReg,
  input  logic       MEM_RegWr,
  input  logic       MEM_MemRd,
  input  logic [4:0] MEM_WrReg,
  input  logic       IRQ,
  output logic       PC_Wr,
  output logic       IFID_Wr,
  output logic       IFID_flush,
  output logic       IDEX_flush,
  output logic       ForwardC,
  output logic       ForwardD,
  output logic       IRQ_take,
  output logic       stalled
);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic ex_match, mem_match;
  logic id_reads_in_id;
  logic h_lu, h_br_exld, h_br_ex, h_br_memld;
  logic hazard, stall_long, br_flush, irq_ok;
  logic pc_wr, ifid_wr, ifid_flush, idex_flush, irq_take;
  logic fwd_c, fwd_d;

  hazard_match u_ex_match (
    .reg_wr     (EX_RegWr),
    .wr_reg     (EX_WrReg),
    .id_rs      (ID_rs),
    .id_rt      (ID_rt),
    .id_uses_rt (ID_UsesRt),
    .match      (ex_match)
  );

  hazard_match u_mem_match (
    .reg_wr     (MEM_RegWr),
    .wr_reg     (MEM_WrReg),
    .id_rs      (ID_rs),
    .id_rt      (ID_rt),
    .id_uses_rt (ID_UsesRt),
    .match      (mem_match)
  );

  // Branches and JR resolve in ID, so they need operands one stage earlier.
  assign id_reads_in_id = ID_Branch || ID_JR;

  assign h_lu       = ex_match && EX_MemRd && !id_reads_in_id;
  assign h_br_exld  = id_reads_in_id && ex_match && EX_MemRd;
  assign h_br_ex    = id_reads_in_id && ex_match && !EX_MemRd;
  assign h_br_memld = id_reads_in_id && mem_match && MEM_MemRd;

  assign hazard     = h_lu || h_br_exld || h_br_ex || h_br_memld;
  assign stall_long = h_br_exld && (LOAD_BR_STALL > 1);
  assign br_flush   = ID_Jump || (ID_Branch && ID_Taken);
  assign irq_ok     = IRQ && !ID_Kernel && !ID_Branch && !ID_Jump;

  assign fwd_c = MEM_RegWr && !MEM_MemRd && (MEM_WrReg != 5'd0) && (MEM_WrReg == ID_rs);
  assign fwd_d = MEM_RegWr && !MEM_MemRd && (MEM_WrReg != 5'd0) && (MEM_WrReg == ID_rt);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    irq_take   = 1'b0;

    case (state_q)
      ST_STALL: begin
        pc_wr      = 1'b0;
        ifid_wr    = 1'b0;
        idex_flush = 1'b1;
        cnt_d      = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
        if (cnt_q <= 2'd1) begin
          state_d = ST_RUN;
        end
      end

      ST_IRQ_HOLD: begin
        if (hazard) begin
          pc_wr      = 1'b0;
          ifid_wr    = 1'b0;
          idex_flush = 1'b1;
        end else begin
          ifid_flush = br_flush;
          cnt_d      = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
          if (cnt_d == 2'd0) begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        if (hazard) begin
          pc_wr      = 1'b0;
          ifid_wr    = 1'b0;
          idex_flush = 1'b1;
          if (stall_long) begin
            cnt_d   = 2'(LOAD_BR_STALL - 1);
            state_d = ST_STALL;
          end
        end else if (irq_ok) begin
          irq_take   = 1'b1;
          ifid_flush = 1'b1;
          cnt_d      = 2'(IRQ_HOLDOFF);
          state_d    = ST_IRQ_HOLD;
        end else begin
          ifid_flush = br_flush;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is held low for the whole time reset is asserted.
  assign PC_Wr      = reset && pc_wr;
  assign IFID_Wr    = reset && ifid_wr;
  assign IFID_flush = reset && ifid_flush;
  assign IDEX_flush = reset && idex_flush;
  assign ForwardC   = reset && fwd_c;
  assign ForwardD   = reset && fwd_d;
  assign IRQ_take   = reset && irq_take;
  assign stalled    = reset && (state_q == ST_STALL);

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed scoreboard bench                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_UsesRt, ID_Branch, ID_Jump, ID_JR, ID_Taken, ID_Kernel;
  logic       EX_RegWr, EX_MemRd;
  logic [4:0] EX_WrReg;
  logic       MEM_RegWr, MEM_MemRd;
  logic [4:0] MEM_WrReg;
  logic       IRQ;
  logic       PC_Wr, IFID_Wr, IFID_flush, IDEX_flush, ForwardC, ForwardD, IRQ_take, stalled;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Vector order: PC_Wr IFID_Wr IFID_flush IDEX_flush ForwardC ForwardD IRQ_take stalled
  localparam logic [7:0] E_ZERO  = 8'b0000_0000;
  localparam logic [7:0] E_RUN   = 8'b1100_0000;
  localparam logic [7:0] E_STALL = 8'b0001_0000;
  localparam logic [7:0] E_STL2  = 8'b0001_0001;
  localparam logic [7:0] E_FLUSH = 8'b1110_0000;
  localparam logic [7:0] E_IRQ   = 8'b1110_0010;

  pipeline_hazard_ctrl #(
    .LOAD_BR_STALL (2),
    .IRQ_HOLDOFF   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_UsesRt  (ID_UsesRt),
    .ID_Branch  (ID_Branch),
    .ID_Jump    (ID_Jump),
    .ID_JR      (ID_JR),
    .ID_Taken   (ID_Taken),
    .ID_Kernel  (ID_Kernel),
    .EX_RegWr   (EX_RegWr),
    .EX_MemRd   (EX_MemRd),
    .EX_WrReg   (EX_WrReg),
    .MEM_RegWr  (MEM_RegWr),
    .MEM_MemRd  (MEM_MemRd),
    .MEM_WrReg  (MEM_WrReg),
    .IRQ        (IRQ),
    .PC_Wr      (PC_Wr),
    .IFID_Wr    (IFID_Wr),
    .IFID_flush (IFID_flush),
    .IDEX_flush (IDEX_flush),
    .ForwardC   (ForwardC),
    .ForwardD   (ForwardD),
    .IRQ_take   (IRQ_take),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_Jump = 1'b0; ID_JR = 1'b0; ID_Taken = 1'b0; ID_Kernel = 1'b0;
    EX_RegWr = 1'b0; EX_MemRd = 1'b0; EX_WrReg = 5'd0;
    MEM_RegWr = 1'b0; MEM_MemRd = 1'b0; MEM_WrReg = 5'd0;
    IRQ = 1'b0;
  endtask

  // Inputs were just driven (1 ns after posedge); record, settle, compare, move to next cycle.
  task automatic step(input logic [7:0] e, input string tag);
    exp_t       x;
    logic [7:0] obs;
    exp_q.push_back('{v: e, tag: tag});
    #2;
    x   = exp_q.pop_front();
    obs = {PC_Wr, IFID_Wr, IFID_flush, IDEX_flush, ForwardC, ForwardD, IRQ_take, stalled};
    checks++;
    assert (obs === x.v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(E_ZERO, "reset_outputs");
    reset = 1'b1;
    step(E_RUN, "idle_run");

    // lw $t0 in EX, add $t1,$t0,$t2 in ID
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5'd8;
    ID_rs = 5'd8; ID_rt = 5'd10; ID_UsesRt = 1;
    step(E_STALL, "loaduse_stall");
    EX_RegWr = 0; EX_MemRd = 0; EX_WrReg = 5'd0;
    step(E_RUN, "loaduse_resume");

    // load into rt that is not read: no dependency
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5'd9;
    ID_rs = 5'd3; ID_rt = 5'd9; ID_UsesRt = 0;
    step(E_RUN, "rt_unused");
    idle();

    // lw $t0 in EX, beq $t0,$t1 in ID: two stall cycles
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5'd8;
    ID_rs = 5'd8; ID_rt = 5'd9; ID_UsesRt = 1; ID_Branch = 1;
    step(E_STALL, "br_exld_stall1");
    EX_RegWr = 0; EX_MemRd = 0; EX_WrReg = 5'd0;
    MEM_RegWr = 1; MEM_MemRd = 1; MEM_WrReg = 5'd8; ID_Taken = 1;
    step(E_STL2, "br_exld_stall2");
    MEM_RegWr = 0; MEM_MemRd = 0; MEM_WrReg = 5'd0;
    step(E_FLUSH, "br_after_stall");
    idle();

    // non-load in EX feeding a JR
    EX_RegWr = 1; EX_WrReg = 5'd31; ID_rs = 5'd31; ID_JR = 1; ID_Jump = 1;
    step(E_STALL, "jr_ex_stall");
    EX_RegWr = 0; EX_WrReg = 5'd0;
    step(E_FLUSH, "jr_resume");
    idle();

    // add $t0 in MEM, bne $t0,$0 in ID: forward, no stall
    MEM_RegWr = 1; MEM_WrReg = 5'd8;
    ID_rs = 5'd8; ID_rt = 5'd0; ID_UsesRt = 1; ID_Branch = 1;
    step(8'b1100_1000, "fwd_c_no_stall");
    ID_Taken = 1;
    step(8'b1110_1000, "fwd_c_taken");
    idle();
    MEM_RegWr = 1; MEM_WrReg = 5'd12; ID_rs = 5'd4; ID_rt = 5'd12;
    step(8'b1100_0100, "fwd_d");
    idle();
    step(E_RUN, "flush_one_cycle");

    // IRQ blocked by jal, then taken, then held off
    IRQ = 1; ID_Jump = 1;
    step(E_FLUSH, "irq_blocked_by_jal");
    ID_Jump = 0;
    step(E_IRQ, "irq_take");
    step(E_RUN, "irq_hold1");
    step(E_RUN, "irq_hold2");
    ID_Kernel = 1;
    step(E_RUN, "irq_kernel_block");
    ID_Kernel = 0;
    step(E_IRQ, "irq_take_again");

    // hazard inside the holdoff window freezes the counter
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5'd8; ID_rs = 5'd8;
    step(E_STALL, "hold_stall");
    idle();
    IRQ = 1;
    step(E_RUN, "hold_frozen1");
    step(E_RUN, "hold_frozen2");
    step(E_IRQ, "irq_after_freeze");
    IRQ = 0;
    step(E_RUN, "hold_end1");
    step(E_RUN, "hold_end2");

    // writes to $0 never match
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5'd0;
    MEM_RegWr = 1; MEM_WrReg = 5'd0; ID_rs = 5'd0;
    step(E_RUN, "zero_reg");
    idle();

    // reset in the middle of a two-cycle branch stall
    EX_RegWr = 1; EX_MemRd = 1; EX_WrReg = 5'd8; ID_rs = 5'd8; ID_Branch = 1;
    step(E_STALL, "pre_reset_stall");
    reset = 1'b0;
    step(E_ZERO, "reset_mid_stall");
    reset = 1'b1;
    idle();
    step(E_RUN, "post_reset_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
